// File: rtl/hex_to_screen_if.sv
`default_nettype none
// ============================================================================
// Module   : hex_to_screen_if
// Purpose  : Request/response bundle for the axial-hex to screen mapper.
//            Request side : valid_in / ready_in carry hex_q, hex_r, hex_size.
//            Response side: valid_out / ready_out carry screen_x, screen_y.
// Modports : master - the client issuing requests and consuming results
//            slave  - the mapper itself
// Revision : 1.0 - initial release
// ============================================================================
interface hex_to_screen_if;
  logic        valid_in;
  logic        ready_in;
  logic [31:0] hex_q;
  logic [31:0] hex_r;
  logic [31:0] hex_size;
  logic [31:0] screen_x;
  logic [31:0] screen_y;
  logic        valid_out;
  logic        ready_out;

  modport master (
    output valid_in, hex_q, hex_r, hex_size, ready_out,
    input  ready_in, screen_x, screen_y, valid_out
  );

  modport slave (
    input  valid_in, hex_q, hex_r, hex_size, ready_out,
    output ready_in, screen_x, screen_y, valid_out
  );
endinterface
`default_nettype wire

// File: rtl/hex_to_screen.sv
`default_nettype none
// ============================================================================
// Module   : hex_to_screen
// Purpose  : Maps a pointy-top axial hex coordinate (q, r) of radius hex_size
//            to the Q16.16 pixel centre of that hex:
//              x = size*sqrt3*(q + r/2),  y = size*1.5*r
//            Uses one shared serial shift-add multiplier, one bit per cycle,
//            for three 32-cycle phases: K_x = size*sqrt3, x = (2q+r)*K_x/2,
//            y = r*K_y. Result appears a fixed 96 cycles after acceptance.
// Ports    : clk       - clock, rising edge
//            reset     - synchronous active-high reset
//            bus       - hex_to_screen_if.slave request/response bundle
// Params   : SQRT3_Q16 - sqrt(3) in unsigned Q16.16
// Revision : 1.0 - initial release
// ============================================================================
module hex_to_screen #(
  parameter logic [31:0] SQRT3_Q16 = 32'd113512
) (
  input  wire logic       clk,
  input  wire logic       reset,
  hex_to_screen_if.slave  bus
);

  localparam logic [2:0] c_idle = 3'd0;
  localparam logic [2:0] c_kx   = 3'd1;
  localparam logic [2:0] c_mx   = 3'd2;
  localparam logic [2:0] c_my   = 3'd3;
  localparam logic [2:0] c_done = 3'd4;

  logic [2:0]  r_state;
  logic [2:0]  w_state_next;
  logic [4:0]  r_cnt;
  logic [31:0] r_q;
  logic [31:0] r_r;
  logic [31:0] r_ky;
  logic [31:0] r_x_res;
  logic [63:0] r_acc;
  logic [63:0] r_mcand;
  logic [31:0] r_mplier;
  logic [31:0] r_screen_x;
  logic [31:0] r_screen_y;

  logic        w_last;
  logic        w_accept;
  logic [63:0] w_acc_next;
  logic [31:0] w_a;
  logic [31:0] w_kx;

  assign w_last     = (r_cnt == 5'd31);
  assign w_accept   = (r_state == c_idle) && bus.valid_in;
  // One serial multiply step: add the shifted multiplicand when the current
  // multiplier LSB is set. Arithmetic wraps at 64 bits, which is what makes
  // sign-extended multiplicands give correct two's-complement products.
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : 64'd0);
  assign w_a        = {r_q[30:0], 1'b0} + r_r;
  assign w_kx       = w_acc_next[47:16];

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------- next-state comb
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_idle:  if (bus.valid_in)  w_state_next = c_kx;
      c_kx:    if (w_last)        w_state_next = c_mx;
      c_mx:    if (w_last)        w_state_next = c_my;
      c_my:    if (w_last)        w_state_next = c_done;
      c_done:  if (bus.ready_out) w_state_next = c_idle;
      default:                    w_state_next = c_idle;
    endcase
  end

  // -------------------------------------------------------------- output comb
  always_comb begin
    bus.ready_in  = (r_state == c_idle);
    bus.valid_out = (r_state == c_done);
  end

  assign bus.screen_x = r_screen_x;
  assign bus.screen_y = r_screen_y;

  // ----------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= 5'd0;
      r_q        <= 32'd0;
      r_r        <= 32'd0;
      r_ky       <= 32'd0;
      r_x_res    <= 32'd0;
      r_acc      <= 64'd0;
      r_mcand    <= 64'd0;
      r_mplier   <= 32'd0;
      r_screen_x <= 32'd0;
      r_screen_y <= 32'd0;
    end else begin
      case (r_state)
        c_idle: begin
          if (w_accept) begin
            r_q      <= bus.hex_q;
            r_r      <= bus.hex_r;
            r_ky     <= bus.hex_size + (bus.hex_size >> 1);
            r_acc    <= 64'd0;
            r_mcand  <= {32'd0, SQRT3_Q16};
            r_mplier <= bus.hex_size;
            r_cnt    <= 5'd0;
          end
        end
        c_kx, c_mx, c_my: begin
          // 5-bit counter wraps to 0 on the last step, ready for the next phase
          r_cnt <= r_cnt + 5'd1;
          if (!w_last) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
          end else begin
            r_acc <= 64'd0;
            case (r_state)
              c_kx: begin
                // K_x is only ever a multiplier, so load it straight in
                r_mcand  <= {{32{w_a[31]}}, w_a};
                r_mplier <= w_kx;
              end
              c_mx: begin
                // Product is (2q+r)*K_x; dropping bit 0 divides by two
                r_x_res  <= w_acc_next[32:1];
                r_mcand  <= {{32{r_r[31]}}, r_r};
                r_mplier <= r_ky;
              end
              default: begin
                r_screen_x <= r_x_res;
                r_screen_y <= w_acc_next[31:0];
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hex_to_screen.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_to_screen
// Purpose  : Self-checking bench for hex_to_screen. Directed corner cases and
//            randomized operands are compared against an arithmetic model of
//            the pointy-top hex-to-pixel mapping, including latency,
//            backpressure, abort-by-reset and reset/request collision.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_to_screen;

  localparam logic [31:0] c_sqrt3 = 32'd113512;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  hex_to_screen_if bus_if ();

  hex_to_screen #(.SQRT3_Q16(c_sqrt3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_x    = 32'd0;
  logic [31:0] exp_y    = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // x = size*sqrt3*(2q+r)/2 and y = size*1.5*r with the stated truncations
  function automatic void model(input logic [31:0] q, input logic [31:0] r,
                                input logic [31:0] size,
                                output logic [31:0] x, output logic [31:0] y);
    longint unsigned kprod;
    logic [31:0]     kx;
    logic [31:0]     ky;
    logic [31:0]     a;
    longint          px;
    longint          py;
    kprod = longint'({32'd0, size}) * longint'({32'd0, c_sqrt3});
    kx    = 32'(kprod >> 16);
    a     = 32'(2 * int'(q) + int'(r));
    px    = longint'(int'(a)) * longint'({32'd0, kx});
    x     = 32'(px >>> 1);
    ky    = size + (size >> 1);
    py    = longint'(int'(r)) * longint'({32'd0, ky});
    y     = 32'(py);
  endfunction

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic junk_inputs();
    bus_if.valid_in = 1'($urandom_range(0, 1));
    bus_if.hex_q    = $urandom;
    bus_if.hex_r    = $urandom;
    bus_if.hex_size = $urandom;
  endtask

  task automatic run_txn(input logic [31:0] q, input logic [31:0] r,
                         input logic [31:0] size, input int bp);
    logic [31:0] mx;
    logic [31:0] my;
    int          lat;
    logic        bad;
    model(q, r, size, mx, my);
    @(negedge clk);
    check("ready_before_accept", 32'(bus_if.ready_in), 32'd1);
    bus_if.valid_in = 1'b1;
    bus_if.hex_q    = q;
    bus_if.hex_r    = r;
    bus_if.hex_size = size;
    cycle();
    lat = 0;
    bad = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      junk_inputs();
      cycle();
      if (bus_if.valid_out) begin
        lat = i;
        break;
      end
      if (bus_if.ready_in || bus_if.screen_x !== exp_x || bus_if.screen_y !== exp_y)
        bad = 1'b1;
    end
    bus_if.valid_in = 1'b0;
    check("latency", 32'(lat), 32'd96);
    check("busy_hold", 32'(bad), 32'd0);
    check("screen_x", bus_if.screen_x, mx);
    check("screen_y", bus_if.screen_y, my);
    bad = 1'b0;
    for (int i = 0; i < bp; i++) begin
      junk_inputs();
      cycle();
      if (!bus_if.valid_out || bus_if.ready_in ||
          bus_if.screen_x !== mx || bus_if.screen_y !== my)
        bad = 1'b1;
    end
    check("backpressure_hold", 32'(bad), 32'd0);
    bus_if.valid_in  = 1'b0;
    bus_if.ready_out = 1'b1;
    cycle();
    bus_if.ready_out = 1'b0;
    check("release_valid_out", 32'(bus_if.valid_out), 32'd0);
    check("release_ready_in", 32'(bus_if.ready_in), 32'd1);
    check("release_hold_x", bus_if.screen_x, mx);
    exp_x = mx;
    exp_y = my;
  endtask

  initial begin
    logic bad;
    bus_if.valid_in  = 1'b0;
    bus_if.ready_out = 1'b0;
    bus_if.hex_q     = 32'd0;
    bus_if.hex_r     = 32'd0;
    bus_if.hex_size  = 32'd0;
    repeat (3) cycle();
    reset = 1'b0;
    check("reset_ready_in", 32'(bus_if.ready_in), 32'd1);
    check("reset_valid_out", 32'(bus_if.valid_out), 32'd0);
    check("reset_screen_x", bus_if.screen_x, 32'd0);
    check("reset_screen_y", bus_if.screen_y, 32'd0);

    // Directed corner cases
    run_txn(32'd0, 32'd0, 32'h0001_0000, 0);
    run_txn(32'd1, 32'd0, 32'h0001_0000, 3);
    check("dir_q1_x", exp_x, 32'h0001_BB68);
    run_txn(32'd0, 32'd1, 32'h0001_0000, 1);
    check("dir_r1_x", exp_x, 32'h0000_DDB4);
    check("dir_r1_y", exp_y, 32'h0001_8000);
    run_txn(32'hFFFF_FFFF, 32'd0, 32'h0002_0000, 10);
    check("dir_qm1_x", exp_x, 32'hFFFC_8930);

    // Randomized operands: half full-range, half small-magnitude
    for (int n = 0; n < 10; n++) begin
      if (n % 2 == 0)
        run_txn($urandom, $urandom, $urandom, int'($urandom_range(0, 4)));
      else
        run_txn(32'($signed(7'($urandom))), 32'($signed(7'($urandom))),
                32'($urandom_range(0, 32'h0010_0000)), int'($urandom_range(0, 4)));
    end

    // Abort by reset at cycle 50 of a transaction
    @(negedge clk);
    bus_if.valid_in = 1'b1;
    bus_if.hex_q    = 32'd5;
    bus_if.hex_r    = 32'd3;
    bus_if.hex_size = 32'h0001_0000;
    cycle();
    bus_if.valid_in = 1'b0;
    repeat (49) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("abort_valid_out", 32'(bus_if.valid_out), 32'd0);
    check("abort_ready_in", 32'(bus_if.ready_in), 32'd1);
    check("abort_screen_x", bus_if.screen_x, 32'd0);
    check("abort_screen_y", bus_if.screen_y, 32'd0);
    bad = 1'b0;
    for (int i = 0; i < 120; i++) begin
      cycle();
      if (bus_if.valid_out) bad = 1'b1;
    end
    check("abort_no_result", 32'(bad), 32'd0);
    exp_x = 32'd0;
    exp_y = 32'd0;
    run_txn(32'd1, 32'd0, 32'h0001_0000, 0);

    // Reset coincident with a request: the request must be dropped
    @(negedge clk);
    reset           = 1'b1;
    bus_if.valid_in = 1'b1;
    bus_if.hex_q    = 32'd1;
    bus_if.hex_r    = 32'd1;
    bus_if.hex_size = 32'h0001_0000;
    cycle();
    reset           = 1'b0;
    bus_if.valid_in = 1'b0;
    check("collide_ready_in", 32'(bus_if.ready_in), 32'd1);
    bad = 1'b0;
    for (int i = 0; i < 110; i++) begin
      cycle();
      if (bus_if.valid_out || !bus_if.ready_in) bad = 1'b1;
    end
    check("collide_not_accepted", 32'(bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute watchdog so the run always terminates
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
